// File: rtl/huffman_pkg.sv
// Shared Huffman codec definitions: table geometry, FSM state encoding and mask helper.
package huffman_pkg;

    localparam int SYM_NUM = 6;
    localparam int CODE_W  = 8;
    localparam int SYM_W   = 3;
    localparam int LEN_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        ERR
    } state_t;

    // A usable mask is non-zero and of the form 2^k-1: adding one clears every set bit.
    function automatic logic mask_ok(input logic [CODE_W-1:0] m);
        logic [CODE_W-1:0] w_next;
        w_next = m + CODE_W'(1);
        return (m != '0) && ((w_next & m) == '0);
    endfunction

endpackage

// File: rtl/huffman_code_lut.sv
// Combinational match of the shifted-in code against the latched table; lowest index wins.
module huffman_code_lut
    import huffman_pkg::*;
(
    input  logic [CODE_W-1:0]              i_acc,
    input  logic [LEN_W-1:0]               i_len,
    input  logic [SYM_NUM-1:0][CODE_W-1:0] i_hc,
    input  logic [SYM_NUM-1:0][CODE_W-1:0] i_m,
    output logic                           o_hit,
    output logic [SYM_W-1:0]               o_idx
);

    logic [CODE_W-1:0] w_len_mask;

    always_comb begin
        w_len_mask = CODE_W'(((CODE_W + 1)'(1) << i_len) - (CODE_W + 1)'(1));
        o_hit      = 1'b0;
        o_idx      = '0;
        for (int unsigned n = 0; n < SYM_NUM; n++) begin
            if (!o_hit && (i_m[n] == w_len_mask) && ((i_acc & i_m[n]) == i_hc[n])) begin
                o_hit = 1'b1;
                o_idx = SYM_W'(n + 1);
            end
        end
    end

endmodule

// File: rtl/huffman_decoder.sv
// Serial prefix-code decoder with a loadable 6-entry table.
// Optional per-symbol saturating counters DCNT1..DCNT6 when HUFF_DEC_CNT_EN is defined.
module huffman_decoder
    import huffman_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] HC1,
    input  logic [CODE_W-1:0] HC2,
    input  logic [CODE_W-1:0] HC3,
    input  logic [CODE_W-1:0] HC4,
    input  logic [CODE_W-1:0] HC5,
    input  logic [CODE_W-1:0] HC6,
    input  logic [CODE_W-1:0] M1,
    input  logic [CODE_W-1:0] M2,
    input  logic [CODE_W-1:0] M3,
    input  logic [CODE_W-1:0] M4,
    input  logic [CODE_W-1:0] M5,
    input  logic [CODE_W-1:0] M6,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              bit_ready,
    output logic              sym_valid,
    output logic [SYM_W-1:0]  sym,
`ifdef HUFF_DEC_CNT_EN
    output logic [7:0]        DCNT1,
    output logic [7:0]        DCNT2,
    output logic [7:0]        DCNT3,
    output logic [7:0]        DCNT4,
    output logic [7:0]        DCNT5,
    output logic [7:0]        DCNT6,
`endif
    output logic              err
);

    state_t                         r_state;
    logic [SYM_NUM-1:0][CODE_W-1:0] r_hc;
    logic [SYM_NUM-1:0][CODE_W-1:0] r_m;
    logic [CODE_W-1:0]              r_acc;
    logic [LEN_W-1:0]               r_len;
    logic                           r_bit_ready;
    logic                           r_sym_valid;
    logic [SYM_W-1:0]               r_sym;
    logic                           r_err;

    logic [SYM_NUM-1:0][CODE_W-1:0] w_hc_in;
    logic [SYM_NUM-1:0][CODE_W-1:0] w_m_in;
    logic [CODE_W-1:0]              w_acc_n;
    logic [LEN_W-1:0]               w_len_n;
    logic                           w_hit;
    logic [SYM_W-1:0]               w_idx;
    logic                           w_table_ok;
    logic                           w_accept;

    assign w_hc_in  = {HC6, HC5, HC4, HC3, HC2, HC1};
    assign w_m_in   = {M6, M5, M4, M3, M2, M1};
    assign w_acc_n  = CODE_W'({r_acc, bit_in});
    assign w_len_n  = r_len + LEN_W'(1);
    assign w_accept = (r_state == RUN) && bit_valid && r_bit_ready;

    always_comb begin
        w_table_ok = 1'b1;
        for (int unsigned n = 0; n < SYM_NUM; n++) begin
            if (!mask_ok(w_m_in[n])) w_table_ok = 1'b0;
        end
    end

    huffman_code_lut u_lut (
        .i_acc (w_acc_n),
        .i_len (w_len_n),
        .i_hc  (r_hc),
        .i_m   (r_m),
        .o_hit (w_hit),
        .o_idx (w_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_hc        <= '0;
            r_m         <= '0;
            r_acc       <= '0;
            r_len       <= '0;
            r_bit_ready <= 1'b0;
            r_sym_valid <= 1'b0;
            r_sym       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_sym_valid <= 1'b0;
            case (r_state)
                IDLE: if (code_valid) r_state <= LOAD;
                LOAD: begin
                    r_hc  <= w_hc_in;
                    r_m   <= w_m_in;
                    r_acc <= '0;
                    r_len <= '0;
                    if (w_table_ok) begin
                        r_state     <= RUN;
                        r_bit_ready <= 1'b1;
                    end else begin
                        r_state <= ERR;
                        r_err   <= 1'b1;
                    end
                end
                RUN: if (w_accept) begin
                    if (w_hit) begin
                        r_sym_valid <= 1'b1;
                        r_sym       <= w_idx;
                        r_acc       <= '0;
                        r_len       <= '0;
                    end else if (w_len_n == LEN_W'(CODE_W)) begin
                        r_state     <= ERR;
                        r_err       <= 1'b1;
                        r_bit_ready <= 1'b0;
                    end else begin
                        r_acc <= w_acc_n;
                        r_len <= w_len_n;
                    end
                end
                ERR:     r_bit_ready <= 1'b0;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bit_ready = r_bit_ready;
    assign sym_valid = r_sym_valid;
    assign sym       = r_sym;
    assign err       = r_err;

`ifdef HUFF_DEC_CNT_EN
    logic [SYM_NUM-1:0][7:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == LOAD) begin
            r_cnt <= '0;
        end else if (w_accept && w_hit) begin
            for (int unsigned n = 0; n < SYM_NUM; n++) begin
                if ((w_idx == SYM_W'(n + 1)) && (r_cnt[n] != '1)) r_cnt[n] <= r_cnt[n] + 8'd1;
            end
        end
    end

    assign DCNT1 = r_cnt[0];
    assign DCNT2 = r_cnt[1];
    assign DCNT3 = r_cnt[2];
    assign DCNT4 = r_cnt[3];
    assign DCNT5 = r_cnt[4];
    assign DCNT6 = r_cnt[5];
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// Scoreboard bench for huffman_decoder: directed bit streams, monitor pops expected symbols.
module tb_huffman_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       code_valid = 1'b0;
    logic [7:0] hc [6];
    logic [7:0] m  [6];
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_ready;
    logic       sym_valid;
    logic [2:0] sym;
    logic       err;
`ifdef HUFF_DEC_CNT_EN
    logic [7:0] dcnt [6];
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int s;
        int c;
    } exp_t;
    exp_t q[$];

    huffman_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .HC1        (hc[0]),
        .HC2        (hc[1]),
        .HC3        (hc[2]),
        .HC4        (hc[3]),
        .HC5        (hc[4]),
        .HC6        (hc[5]),
        .M1         (m[0]),
        .M2         (m[1]),
        .M3         (m[2]),
        .M4         (m[3]),
        .M5         (m[4]),
        .M6         (m[5]),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .bit_ready  (bit_ready),
        .sym_valid  (sym_valid),
        .sym        (sym),
`ifdef HUFF_DEC_CNT_EN
        .DCNT1      (dcnt[0]),
        .DCNT2      (dcnt[1]),
        .DCNT3      (dcnt[2]),
        .DCNT4      (dcnt[3]),
        .DCNT5      (dcnt[4]),
        .DCNT6      (dcnt[5]),
`endif
        .err        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must correspond to the oldest queued expectation, at the right cycle.
    always @(negedge clk) begin
        if (!reset && sym_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_sym: got sym=%0d, expected no pulse (cycle %0d)", sym, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sym", int'(sym), e.s);
                check("sym_latency", cyc, e.c);
            end
        end
    end

    task automatic send_bit(input logic b, input int exp_sym);
        @(posedge clk); #1;
        bit_valid = 1'b1;
        bit_in    = b;
        if (exp_sym != 0) q.push_back('{s: exp_sym, c: cyc + 1});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bit_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset      = 1'b1;
        code_valid = 1'b0;
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
        #2;
        check("rst_bit_ready", int'(bit_ready), 0);
        check("rst_sym_valid", int'(sym_valid), 0);
        check("rst_sym", int'(sym), 0);
        check("rst_err", int'(err), 0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic set_t();
        logic [7:0] tc [6];
        logic [7:0] tm [6];
        tc = '{8'h00, 8'h02, 8'h06, 8'h0E, 8'h1E, 8'h1F};
        tm = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};
        for (int i = 0; i < 6; i++) begin
            hc[i] = tc[i];
            m[i]  = tm[i];
        end
    endtask

    task automatic load_and_wait();
        int k;
        code_valid = 1'b1;
        k = 0;
        while (!bit_ready && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        check("load_ready", int'(bit_ready), 1);
        check("load_err", int'(err), 0);
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            hc[i] = '0;
            m[i]  = '0;
        end
        do_reset();

        // Table T: 1,0,0 back to back -> 2 then 1, no bubble
        set_t();
        load_and_wait();
        send_bit(1'b1, 0);
        send_bit(1'b0, 2);
        send_bit(1'b0, 1);
        code_valid = 1'b0;
        idle(2);
        check("sym_hold", int'(sym), 1);
        // Remaining codes with the table source withdrawn
        send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b0, 3);
        send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b0, 4);
        send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
        send_bit(1'b0, 5);
        // 11111 with two idle cycles between bits -> single 6
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1, (i == 4) ? 6 : 0);
            idle(2);
        end
        check("t_err", int'(err), 0);

        // Illegal mask M3=05 -> ERR straight out of LOAD
        do_reset();
        set_t();
        m[2] = 8'h05;
        code_valid = 1'b1;
        @(posedge clk); #1;
        check("badmask_err_in_load", int'(err), 0);
        @(posedge clk); #1;
        check("badmask_err", int'(err), 1);
        check("badmask_ready", int'(bit_ready), 0);
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        idle(3);
        check("badmask_ready_hold", int'(bit_ready), 0);
        check("badmask_err_hold", int'(err), 1);

        // All masks FF, HCn=n: 8 ones never match -> err, no pulse
        do_reset();
        for (int i = 0; i < 6; i++) begin
            hc[i] = 8'(i + 1);
            m[i]  = 8'hFF;
        end
        load_and_wait();
        for (int i = 0; i < 7; i++) send_bit(1'b1, 0);
        idle(0);
        check("overflow_err_before", int'(err), 0);
        send_bit(1'b1, 0);
        idle(1);
        check("overflow_err", int'(err), 1);
        check("overflow_ready", int'(bit_ready), 0);
        idle(2);

        // Partial code 11 discarded by reset; reload T, bit 0 -> sym 1 only
        do_reset();
        set_t();
        load_and_wait();
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        idle(1);
        do_reset();
        idle(2);
        set_t();
        load_and_wait();
        send_bit(1'b0, 1);
        idle(3);

`ifdef HUFF_DEC_CNT_EN
        do_reset();
        set_t();
        load_and_wait();
        for (int i = 0; i < 300; i++) send_bit(1'b0, 1);
        idle(3);
        check("dcnt1_sat", int'(dcnt[0]), 255);
        for (int i = 1; i < 6; i++) check("dcnt_other", int'(dcnt[i]), 0);
`endif

        idle(3);
        check("scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
